// File: rtl/minmax_tracker.sv
// Running max/min tracker with first-occurrence indices over a sequence of unsigned samples.
// Latency: done pulses one cycle after the edge that accepts the last sample (len=0: cycle after start).
// Backpressure: in_ready is high only in RUN; in_valid=0 bubbles hold all state.
//
// Ports:
//   Clk, Rst            rising-edge clock, synchronous active-high reset
//   start, len          begin a sequence of len samples (sampled only in IDLE)
//   in_valid/in_data    sample stream, accepted when in_valid && in_ready
//   in_ready, busy      decoded from the state register
//   max_out/min_out     running extremes, registered and held after DONE
//   max_idx/min_idx     0-based index of the first occurrence of each extreme
//   done                one-cycle pulse while results are final

// Unsigned magnitude comparator: reports a>b, a<b, a==b.
module minmax_comp #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         gt_o,
    output logic         lt_o,
    output logic         eq_o
);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
endmodule

module minmax_tracker #(
    parameter int DATAWIDTH = 64,
    parameter int CNTWIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [CNTWIDTH-1:0]  len,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] max_out,
    output logic [DATAWIDTH-1:0] min_out,
    output logic [CNTWIDTH-1:0]  max_idx,
    output logic [CNTWIDTH-1:0]  min_idx,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNTWIDTH-1:0]   len_q, len_d;
    logic [CNTWIDTH-1:0]   count_q, count_d;
    logic [DATAWIDTH-1:0]  max_q, max_d;
    logic [DATAWIDTH-1:0]  min_q, min_d;
    logic [CNTWIDTH-1:0]   max_idx_q, max_idx_d;
    logic [CNTWIDTH-1:0]   min_idx_q, min_idx_d;
    logic                  done_q, done_d;

    logic max_gt, max_lt, max_eq;
    logic min_gt, min_lt, min_eq;
    logic accept;
    logic last_sample;

    minmax_comp #(.W(DATAWIDTH)) u_cmp_max (
        .a_i  (in_data),
        .b_i  (max_q),
        .gt_o (max_gt),
        .lt_o (max_lt),
        .eq_o (max_eq)
    );

    minmax_comp #(.W(DATAWIDTH)) u_cmp_min (
        .a_i  (in_data),
        .b_i  (min_q),
        .gt_o (min_gt),
        .lt_o (min_lt),
        .eq_o (min_eq)
    );

    assign accept      = in_valid && (state_q == S_RUN);
    // len_q is never 0 while in RUN, so len_q-1 cannot underflow here.
    assign last_sample = accept && (count_q == (len_q - CNTWIDTH'(1)));

    // State register plus result/bookkeeping registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            count_q   <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_sample) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: results clear on start acceptance, update on accepted samples.
    always_comb begin
        len_d     = len_q;
        count_d   = count_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;

        if (state_q == S_IDLE && start) begin
            len_d     = len;
            count_d   = '0;
            max_d     = '0;
            min_d     = '0;
            max_idx_d = '0;
            min_idx_d = '0;
        end else if (accept) begin
            count_d = count_q + CNTWIDTH'(1);
            if (count_q == '0) begin
                // First sample seeds both extremes regardless of the comparators.
                max_d     = in_data;
                min_d     = in_data;
                max_idx_d = '0;
                min_idx_d = '0;
            end else begin
                // Strict gt/lt only: equal samples leave the first occurrence in place.
                if (max_gt && !max_eq) begin
                    max_d     = in_data;
                    max_idx_d = count_q;
                end
                if (min_lt && !min_eq) begin
                    min_d     = in_data;
                    min_idx_d = count_q;
                end
            end
        end
    end

    // done is registered so it is high exactly while the state register holds DONE.
    assign done_d = (state_d == S_DONE);

    // Output decode.
    always_comb begin
        in_ready = (state_q == S_RUN);
        busy     = (state_q == S_RUN) || (state_q == S_DONE);
    end

    assign max_out = max_q;
    assign min_out = min_q;
    assign max_idx = max_idx_q;
    assign min_idx = min_idx_q;
    assign done    = done_q;

    // Unused comparator flags are kept for visibility of the full COMP interface.
    logic unused_flags;
    assign unused_flags = max_lt ^ min_gt;

endmodule

// File: tb/tb_minmax_tracker.sv
module tb_minmax_tracker;
    localparam int DW = 64;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] max_out, min_out;
    logic [CW-1:0] max_idx, min_idx;
    logic          busy, done;

    typedef struct {
        logic [DW-1:0] mx;
        logic [DW-1:0] mn;
        logic [CW-1:0] mxi;
        logic [CW-1:0] mni;
    } res_t;

    res_t sb[$];
    res_t exp_r;

    int vectors = 0;
    int miscompares = 0;

    // Stimulus tables shared by the sequence driver.
    logic [DW-1:0] samp   [0:7];
    int            bubble [0:7];
    int            poke_start_at;

    int  cycles;
    bit  timeout;
    bit  busy_ok;

    minmax_tracker #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .max_out  (max_out),
        .min_out  (min_out),
        .max_idx  (max_idx),
        .min_idx  (min_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 8; i++) begin
            samp[i]   = '0;
            bubble[i] = 0;
        end
        poke_start_at = -1;
    endtask

    // Reference model: pushes the expected result for samp[0..n-1].
    task automatic push_expected(input int n);
        res_t r;
        r.mx = '0; r.mn = '0; r.mxi = '0; r.mni = '0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                r.mx = samp[0]; r.mn = samp[0]; r.mxi = '0; r.mni = '0;
            end else begin
                if (samp[i] > r.mx) begin r.mx = samp[i]; r.mxi = CW'(i); end
                if (samp[i] < r.mn) begin r.mn = samp[i]; r.mni = CW'(i); end
            end
        end
        sb.push_back(r);
    endtask

    // Drives start + n samples (with bubbles), returns edges until done is seen.
    task automatic drive_seq(input int n, output int ncyc, output bit tmo, output bit bsy);
        start = 1'b0; in_valid = 1'b0;
        step();
        push_expected(n);
        bsy  = 1'b1;
        tmo  = 1'b0;
        start = 1'b1; len = CW'(n);
        step();
        ncyc = 1;
        start = 1'b0;
        if (busy !== 1'b1) bsy = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < bubble[i]; b++) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                step();
                ncyc++;
                if (busy !== 1'b1) bsy = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = samp[i];
            if (i == poke_start_at) begin
                start = 1'b1; len = CW'(7);
            end
            step();
            ncyc++;
            start = 1'b0;
            if (busy !== 1'b1) bsy = 1'b0;
        end
        in_valid = 1'b0;
        begin : wait_done
            for (int k = 0; k < 20; k++) begin
                if (done === 1'b1) disable wait_done;
                step();
                ncyc++;
                if (busy !== 1'b1 && done !== 1'b1) bsy = 1'b0;
            end
            tmo = 1'b1;
        end
    endtask

    task automatic pop_exp(output bit ok);
        ok = 1'b0;
        if (sb.size() != 0) begin
            exp_r = sb.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        step(); step();
        vectors++;
        if ({in_ready, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got ready/busy/done=%b required 000", {in_ready, busy, done});
        end
        vectors++;
        if (max_out !== '0 || min_out !== '0 || max_idx !== '0 || min_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got max=%h min=%h mi=%0d ni=%0d required all 0",
                     max_out, min_out, max_idx, min_idx);
        end
        Rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        clear_tables();
        samp[0] = 7; samp[1] = 3; samp[2] = 9; samp[3] = 3; samp[4] = 1;
        drive_seq(5, cycles, timeout, busy_ok);
        vectors++;
        if (timeout || cycles != 6) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d edges (timeout=%0d) required 6", cycles, timeout);
        end
        vectors++;
        if (!busy_ok) begin
            miscompares++;
            $display("FAIL basic_busy: busy dropped during sequence, required high");
        end
        pop_exp(ok);
        vectors++;
        if (!ok || max_out !== exp_r.mx || max_idx !== exp_r.mxi) begin
            miscompares++;
            $display("FAIL basic_max: got %0d@%0d required %0d@%0d", max_out, max_idx, exp_r.mx, exp_r.mxi);
        end
        vectors++;
        if (!ok || min_out !== exp_r.mn || min_idx !== exp_r.mni) begin
            miscompares++;
            $display("FAIL basic_min: got %0d@%0d required %0d@%0d", min_out, min_idx, exp_r.mn, exp_r.mni);
        end
        step();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b after DONE required 0 0", done, busy);
        end
    endtask

    task automatic test_ties_bubbles();
        bit ok;
        clear_tables();
        samp[0] = 5; samp[1] = 5; samp[2] = 2; samp[3] = 2;
        bubble[1] = 2;
        drive_seq(4, cycles, timeout, busy_ok);
        vectors++;
        if (timeout || cycles != 7) begin
            miscompares++;
            $display("FAIL ties_latency: got %0d edges (timeout=%0d) required 7", cycles, timeout);
        end
        pop_exp(ok);
        vectors++;
        if (!ok || max_idx !== exp_r.mxi || min_idx !== exp_r.mni ||
            max_out !== exp_r.mx || min_out !== exp_r.mn) begin
            miscompares++;
            $display("FAIL ties_idx: got max=%0d@%0d min=%0d@%0d required %0d@%0d %0d@%0d",
                     max_out, max_idx, min_out, min_idx, exp_r.mx, exp_r.mxi, exp_r.mn, exp_r.mni);
        end
    endtask

    task automatic test_width_extremes();
        bit ok;
        clear_tables();
        samp[0] = 64'h0;
        samp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        samp[2] = 64'h8000_0000_0000_0000;
        drive_seq(3, cycles, timeout, busy_ok);
        pop_exp(ok);
        vectors++;
        if (timeout || !ok || max_out !== exp_r.mx || max_idx !== exp_r.mxi) begin
            miscompares++;
            $display("FAIL width_max: got %h@%0d required %h@%0d", max_out, max_idx, exp_r.mx, exp_r.mxi);
        end
        vectors++;
        if (!ok || min_out !== exp_r.mn || min_idx !== exp_r.mni) begin
            miscompares++;
            $display("FAIL width_min: got %h@%0d required %h@%0d", min_out, min_idx, exp_r.mn, exp_r.mni);
        end
    endtask

    task automatic test_len_zero();
        bit ok;
        clear_tables();
        drive_seq(0, cycles, timeout, busy_ok);
        vectors++;
        if (timeout || cycles != 1) begin
            miscompares++;
            $display("FAIL len0_latency: got %0d edges (timeout=%0d) required 1", cycles, timeout);
        end
        pop_exp(ok);
        vectors++;
        if (!ok || max_out !== exp_r.mx || min_out !== exp_r.mn ||
            max_idx !== exp_r.mxi || min_idx !== exp_r.mni) begin
            miscompares++;
            $display("FAIL len0_results: got max=%h min=%h mi=%0d ni=%0d required all 0",
                     max_out, min_out, max_idx, min_idx);
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        clear_tables();
        samp[0] = 40; samp[1] = 12; samp[2] = 90;
        samp[3] = 1; samp[4] = 200;
        poke_start_at = 1;
        drive_seq(3, cycles, timeout, busy_ok);
        vectors++;
        if (timeout || cycles != 4) begin
            miscompares++;
            $display("FAIL restart_latency: got %0d edges (timeout=%0d) required 4", cycles, timeout);
        end
        pop_exp(ok);
        vectors++;
        if (!ok || max_out !== exp_r.mx || min_out !== exp_r.mn ||
            max_idx !== exp_r.mxi || min_idx !== exp_r.mni) begin
            miscompares++;
            $display("FAIL restart_results: got max=%0d@%0d min=%0d@%0d required %0d@%0d %0d@%0d",
                     max_out, max_idx, min_out, min_idx, exp_r.mx, exp_r.mxi, exp_r.mn, exp_r.mni);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start = 1'b0; in_valid = 1'b0;
        step();
        start = 1'b1; len = CW'(4);
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8; step();
        in_data = 4; step();
        in_valid = 1'b0;
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        vectors++;
        if ({in_ready, busy, done} !== 3'b000 || max_out !== '0 || min_out !== '0 ||
            max_idx !== '0 || min_idx !== '0) begin
            miscompares++;
            $display("FAIL midreset: got rdy/busy/done=%b max=%h min=%h mi=%0d ni=%0d required all 0",
                     {in_ready, busy, done}, max_out, min_out, max_idx, min_idx);
        end
        clear_tables();
        samp[0] = 6;
        drive_seq(1, cycles, timeout, busy_ok);
        pop_exp(ok);
        vectors++;
        if (timeout || !ok || max_out !== exp_r.mx || min_out !== exp_r.mn ||
            max_idx !== exp_r.mxi || min_idx !== exp_r.mni || cycles != 2) begin
            miscompares++;
            $display("FAIL midreset_rerun: got max=%0d@%0d min=%0d@%0d edges=%0d required 6@0 6@0 edges=2",
                     max_out, max_idx, min_out, min_idx, cycles);
        end
    endtask

    task automatic test_result_hold();
        bit ok;
        bit bad;
        clear_tables();
        samp[0] = 33; samp[1] = 77; samp[2] = 11; samp[3] = 50;
        drive_seq(4, cycles, timeout, busy_ok);
        pop_exp(ok);
        vectors++;
        if (timeout || !ok || max_out !== exp_r.mx || min_out !== exp_r.mn ||
            max_idx !== exp_r.mxi || min_idx !== exp_r.mni) begin
            miscompares++;
            $display("FAIL hold_run: got max=%0d@%0d min=%0d@%0d required %0d@%0d %0d@%0d",
                     max_out, max_idx, min_out, min_idx, exp_r.mx, exp_r.mxi, exp_r.mn, exp_r.mni);
        end
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = DW'({$urandom, $urandom});
            step();
            bad = (in_ready !== 1'b0) || (max_out !== exp_r.mx) || (min_out !== exp_r.mn) ||
                  (max_idx !== exp_r.mxi) || (min_idx !== exp_r.mni);
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got rdy=%b max=%0d@%0d min=%0d@%0d required rdy=0 %0d@%0d %0d@%0d",
                         c, in_ready, max_out, max_idx, min_out, min_idx,
                         exp_r.mx, exp_r.mxi, exp_r.mn, exp_r.mni);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties_bubbles();
        test_width_extremes();
        test_len_zero();
        test_ignored_start();
        test_reset_mid();
        test_result_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
